serial_mod_adder: RTL

Digit-serial modulo-2^WIDTH adder for the SHA-256 round datapath, consuming the ripple adder cell one digit per cycle. It accepts two operands via valid/ready and walks DIGIT_W bits per cycle, LSB first, through a DIGIT_W-bit full-adder chain with a registered inter-digit carry. It returns the sum and the final carry via valid/ready. It trades latency for area wherever the compression and schedule logic needs a 32-bit mod-2^32 add.

---
 rtl/serial_mod_adder_pkg.sv | 21 ++
 rtl/serial_mod_adder_if.sv | 23 ++
 rtl/serial_mod_adder_digit_adder.sv | 36 +++
 rtl/serial_mod_adder.sv | 90 +++++++++
 4 files changed

// File: rtl/serial_mod_adder_pkg.sv
// Shared SHA-256 datapath definitions: FSM encodings, word width and the
// counter-sizing helper used by the digit-serial adder.
package sha256_defs;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so a single-digit walk still has a counter bit
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_mod_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
interface serial_mod_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/serial_mod_adder_digit_adder.sv
// DIGIT_W-bit ripple-carry chain built from single-bit full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] s,
  output logic               c_out
);
  logic [DIGIT_W:0] c;

  assign c[0]  = c_in;
  assign c_out = c[DIGIT_W];

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .s    (s[i]),
      .c_out(c[i+1])
    );
  end
endmodule

// File: rtl/serial_mod_adder.sv
// Digit-serial mod-2^WIDTH adder: walks DIGIT_W bits per cycle, LSB first,
// carrying between digits in a register; result handed off via valid/ready.
module serial_mod_adder
  import sha256_defs::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int DIGIT_W = 1
) (
  input logic               clk,
  input logic               rst,
  serial_mod_adder_if.slave bus
);
  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state_q;
  logic               in_ready_q, out_valid_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q, cout_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [DIGIT_W-1:0] dig_s;
  logic               dig_c;
  logic [WIDTH-1:0]   sum_d;

  digit_adder #(.DIGIT_W(DIGIT_W)) u_digit (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (b_q[DIGIT_W-1:0]),
    .c_in (carry_q),
    .s    (dig_s),
    .c_out(dig_c)
  );

  // New digit enters at the MSB end so after N shifts the word is aligned
  assign sum_d = (sum_q >> DIGIT_W) | (WIDTH'(dig_s) << (WIDTH - DIGIT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q        <= bus.a;
          b_q        <= bus.b;
          carry_q    <= 1'b0;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= dig_c;
          a_q     <= a_q >> DIGIT_W;
          b_q     <= b_q >> DIGIT_W;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            cout_q      <= dig_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule
